// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared types, address map and region decode for the CPU bus responder
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_ROM,
        REGION_OPEN
    } region_e;

    typedef enum logic [1:0] {
        IDLE,
        RAM_RD,
        ROM_WAIT,
        DONE
    } responder_state_e;

    localparam logic [15:0] RAM_TOP  = 16'h1FFF;
    localparam logic [15:0] ROM_BASE = 16'h8000;

    function automatic region_e decode_region(input logic [15:0] address);
        if (address <= RAM_TOP) begin
            return REGION_RAM;
        end else if (address >= ROM_BASE) begin
            return REGION_ROM;
        end else begin
            return REGION_OPEN;
        end
    endfunction

endpackage

// File: rtl/cpu_work_ram.sv
// rtl/cpu_work_ram.sv - single-port synchronous work RAM, one-cycle read latency
module cpu_work_ram #(
    parameter int RAM_ADDR_WIDTH = 11
) (
    input  logic                      clock_i,
    input  logic                      write_enable_i,
    input  logic [RAM_ADDR_WIDTH-1:0] address_i,
    input  logic [7:0]                data_i,
    output logic [7:0]                data_o
);

    logic [7:0] mem [2**RAM_ADDR_WIDTH];

    always_ff @(posedge clock_i) begin
        if (write_enable_i) begin
            mem[address_i] <= data_i;
        end
        data_o <= mem[address_i];
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - CPU bus target: work RAM, ROM via req/ack port, open bus
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 11,
    parameter int ROM_TIMEOUT    = 64
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        cycle_strobe_i,
    input  logic [15:0] address_i,
    input  logic        bus_read_i,
    input  logic        bus_write_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        data_valid_o,
    output logic [14:0] mem_address_o,
    output logic        mem_request_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_data_i,
    output logic        bus_error_o
);

    localparam int COUNT_W = $clog2(ROM_TIMEOUT + 1);
    localparam logic [COUNT_W-1:0] TIMEOUT_VAL = COUNT_W'(ROM_TIMEOUT);

    responder_state_e state, state_next;
    logic               pending, pending_next;
    logic               stale, stale_next, stale_now;
    logic [7:0]         open_bus, open_bus_next;
    logic [COUNT_W-1:0] count, count_next, count_inc;
    logic [7:0]         data_next;
    logic               valid_next, request_next, error_next, ram_we;
    logic [14:0]        mem_address_next;
    logic [7:0]         ram_q;

    cpu_work_ram #(.RAM_ADDR_WIDTH(RAM_ADDR_WIDTH)) u_ram (
        .clock_i        (clock_i),
        .write_enable_i (ram_we),
        .address_i      (address_i[RAM_ADDR_WIDTH-1:0]),
        .data_i         (data_i),
        .data_o         (ram_q)
    );

    assign count_inc = count + 1'b1;
    assign stale_now = stale | cycle_strobe_i;

    always_comb begin
        state_next       = state;
        pending_next     = pending;
        stale_next       = stale;
        open_bus_next    = open_bus;
        count_next       = count;
        data_next        = data_o;
        valid_next       = data_valid_o;
        request_next     = mem_request_o;
        mem_address_next = mem_address_o;
        error_next       = 1'b0;
        ram_we           = 1'b0;

        if (cycle_strobe_i) begin
            pending_next = 1'b1;
            valid_next   = 1'b0;
        end

        unique case (state)
            IDLE: begin
                // The address is only meaningful the cycle after a strobe
                if (pending && !cycle_strobe_i) begin
                    pending_next = 1'b0;
                    if (bus_write_i) begin
                        open_bus_next = data_i;
                        ram_we        = (decode_region(address_i) == REGION_RAM);
                        valid_next    = 1'b1;
                        state_next    = DONE;
                    end else if (bus_read_i) begin
                        unique case (decode_region(address_i))
                            REGION_RAM: state_next = RAM_RD;
                            REGION_ROM: begin
                                request_next     = 1'b1;
                                mem_address_next = address_i[14:0];
                                count_next       = '0;
                                stale_next       = 1'b0;
                                state_next       = ROM_WAIT;
                            end
                            default: begin
                                data_next  = open_bus;
                                valid_next = 1'b1;
                                state_next = DONE;
                            end
                        endcase
                    end
                end
            end
            RAM_RD: begin
                if (cycle_strobe_i) begin
                    state_next = IDLE;
                end else begin
                    data_next     = ram_q;
                    open_bus_next = ram_q;
                    valid_next    = 1'b1;
                    state_next    = DONE;
                end
            end
            ROM_WAIT: begin
                // A superseded read still runs to ack/timeout so the mem port stays legal
                stale_next = stale_now;
                if (mem_ack_i || count_inc == TIMEOUT_VAL) begin
                    request_next = 1'b0;
                    error_next   = !mem_ack_i;
                    if (stale_now) begin
                        pending_next = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        data_next     = mem_ack_i ? mem_data_i : open_bus;
                        open_bus_next = mem_ack_i ? mem_data_i : open_bus;
                        valid_next    = 1'b1;
                        state_next    = DONE;
                    end
                end else begin
                    count_next = count_inc;
                end
            end
            DONE: begin
                if (cycle_strobe_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state         <= IDLE;
            pending       <= 1'b1;
            stale         <= 1'b0;
            open_bus      <= 8'h00;
            count         <= '0;
            data_o        <= 8'h00;
            data_valid_o  <= 1'b0;
            mem_request_o <= 1'b0;
            mem_address_o <= 15'h0000;
            bus_error_o   <= 1'b0;
        end else begin
            state         <= state_next;
            pending       <= pending_next;
            stale         <= stale_next;
            open_bus      <= open_bus_next;
            count         <= count_next;
            data_o        <= data_next;
            data_valid_o  <= valid_next;
            mem_request_o <= request_next;
            mem_address_o <= mem_address_next;
            bus_error_o   <= error_next;
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb/tb_cpu_bus_responder.sv - directed self-checking bench for cpu_bus_responder
module tb_cpu_bus_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cycle_strobe = 1'b0;
    logic [15:0] address = 16'h0000;
    logic        bus_read = 1'b0;
    logic        bus_write = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        data_valid;
    logic [14:0] mem_address;
    logic        mem_request;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic        bus_error;

    int compared = 0;
    int mismatched = 0;

    cpu_bus_responder #(.RAM_ADDR_WIDTH(11), .ROM_TIMEOUT(64)) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .cycle_strobe_i (cycle_strobe),
        .address_i      (address),
        .bus_read_i     (bus_read),
        .bus_write_i    (bus_write),
        .data_i         (wdata),
        .data_o         (rdata),
        .data_valid_o   (data_valid),
        .mem_address_o  (mem_address),
        .mem_request_o  (mem_request),
        .mem_ack_i      (mem_ack),
        .mem_data_i     (mem_data),
        .bus_error_o    (bus_error)
    );

    always #5 clock = ~clock;

    // Leaves the caller at the negedge just after the strobe edge
    task automatic strobe_req(input logic [15:0] a, input logic rd, input logic wr, input logic [7:0] d);
        @(negedge clock);
        address = a; bus_read = rd; bus_write = wr; wdata = d; cycle_strobe = 1'b1;
        @(negedge clock);
        cycle_strobe = 1'b0;
    endtask

    task automatic test_reset;
        address = 16'hFFFC; bus_read = 1'b1; reset = 1'b1;
        repeat (3) @(negedge clock);
        compared++; if (rdata !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h expected 00", rdata); end
        compared++; if (data_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
        compared++; if (mem_request !== 1'b0 || bus_error !== 1'b0 || mem_address !== 15'h0) begin mismatched++; $display("FAIL reset_mem: got req=%b err=%b addr=%h expected 0/0/0000", mem_request, bus_error, mem_address); end
        reset = 1'b0;
        @(negedge clock);
        compared++; if (mem_request !== 1'b1) begin mismatched++; $display("FAIL boot_request: got %b expected 1", mem_request); end
        compared++; if (mem_address !== 15'h7FFC) begin mismatched++; $display("FAIL boot_address: got %h expected 7ffc", mem_address); end
        compared++; if (data_valid !== 1'b0) begin mismatched++; $display("FAIL boot_valid_early: got %b expected 0", data_valid); end
        @(negedge clock);
        @(negedge clock);
        mem_ack = 1'b1; mem_data = 8'h34;
        @(negedge clock);
        mem_ack = 1'b0;
        compared++; if (data_valid !== 1'b1 || rdata !== 8'h34) begin mismatched++; $display("FAIL boot_data: got valid=%b data=%h expected 1/34", data_valid, rdata); end
        compared++; if (mem_request !== 1'b0) begin mismatched++; $display("FAIL boot_request_drop: got %b expected 0", mem_request); end
    endtask

    task automatic test_ram_mirror;
        strobe_req(16'h0123, 1'b0, 1'b1, 8'h5A);
        compared++; if (data_valid !== 1'b0) begin mismatched++; $display("FAIL wr_valid_early: got %b expected 0", data_valid); end
        @(negedge clock);
        compared++; if (data_valid !== 1'b1) begin mismatched++; $display("FAIL wr_valid_1clk: got %b expected 1", data_valid); end
        strobe_req(16'h0923, 1'b1, 1'b0, 8'h00);
        compared++; if (data_valid !== 1'b0) begin mismatched++; $display("FAIL rd_valid_0clk: got %b expected 0", data_valid); end
        @(negedge clock);
        compared++; if (data_valid !== 1'b0) begin mismatched++; $display("FAIL rd_valid_1clk: got %b expected 0", data_valid); end
        @(negedge clock);
        compared++; if (data_valid !== 1'b1 || rdata !== 8'h5A) begin mismatched++; $display("FAIL rd_mirror_0923: got valid=%b data=%h expected 1/5a", data_valid, rdata); end
    endtask

    task automatic test_open_bus;
        strobe_req(16'h0200, 1'b0, 1'b1, 8'hA7); @(negedge clock);
        strobe_req(16'h0300, 1'b0, 1'b1, 8'h11); @(negedge clock);
        strobe_req(16'h0200, 1'b1, 1'b0, 8'h00); @(negedge clock); @(negedge clock);
        compared++; if (rdata !== 8'hA7) begin mismatched++; $display("FAIL rd_0200: got %h expected a7", rdata); end
        strobe_req(16'h4016, 1'b1, 1'b0, 8'h00);
        compared++; if (data_valid !== 1'b0) begin mismatched++; $display("FAIL open_valid_early: got %b expected 0", data_valid); end
        @(negedge clock);
        compared++; if (data_valid !== 1'b1 || rdata !== 8'hA7) begin mismatched++; $display("FAIL open_bus_4016: got valid=%b data=%h expected 1/a7", data_valid, rdata); end
    endtask

    task automatic test_rom_timeout;
        int req_cycles = 0;
        int err_pulses = 0;
        strobe_req(16'h8123, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 200; i++) begin
            if (mem_request === 1'b1) req_cycles++;
            if (bus_error === 1'b1) err_pulses++;
            if (data_valid === 1'b1) break;
            @(negedge clock);
        end
        compared++; if (req_cycles !== 64) begin mismatched++; $display("FAIL timeout_req_cycles: got %0d expected 64", req_cycles); end
        compared++; if (err_pulses !== 1 || bus_error !== 1'b1) begin mismatched++; $display("FAIL timeout_error: got pulses=%0d err=%b expected 1/1", err_pulses, bus_error); end
        compared++; if (data_valid !== 1'b1 || rdata !== 8'hA7) begin mismatched++; $display("FAIL timeout_data: got valid=%b data=%h expected 1/a7", data_valid, rdata); end
        @(negedge clock);
        compared++; if (bus_error !== 1'b0 || mem_request !== 1'b0) begin mismatched++; $display("FAIL timeout_after: got err=%b req=%b expected 0/0", bus_error, mem_request); end
    endtask

    task automatic test_stale_rom;
        logic saw_ee = 1'b0;
        strobe_req(16'h0010, 1'b0, 1'b1, 8'h77); @(negedge clock);
        strobe_req(16'h8000, 1'b1, 1'b0, 8'h00);
        @(negedge clock);
        compared++; if (mem_request !== 1'b1 || mem_address !== 15'h0000) begin mismatched++; $display("FAIL stale_request: got req=%b addr=%h expected 1/0000", mem_request, mem_address); end
        strobe_req(16'h0010, 1'b1, 1'b0, 8'h00);
        compared++; if (mem_request !== 1'b1) begin mismatched++; $display("FAIL stale_req_held: got %b expected 1", mem_request); end
        mem_ack = 1'b1; mem_data = 8'hEE;
        @(negedge clock);
        mem_ack = 1'b0;
        compared++; if (mem_request !== 1'b0 || data_valid !== 1'b0) begin mismatched++; $display("FAIL stale_ack: got req=%b valid=%b expected 0/0", mem_request, data_valid); end
        for (int i = 0; i < 10; i++) begin
            if (rdata === 8'hEE) saw_ee = 1'b1;
            if (data_valid === 1'b1) break;
            @(negedge clock);
        end
        compared++; if (data_valid !== 1'b1 || rdata !== 8'h77) begin mismatched++; $display("FAIL stale_next_read: got valid=%b data=%h expected 1/77", data_valid, rdata); end
        compared++; if (saw_ee !== 1'b0) begin mismatched++; $display("FAIL stale_discard: got saw_ee=%b expected 0", saw_ee); end
    endtask

    task automatic test_rom_write;
        logic saw_req = 1'b0;
        strobe_req(16'h0000, 1'b0, 1'b1, 8'h42); @(negedge clock);
        strobe_req(16'h9000, 1'b0, 1'b1, 8'h3C);
        saw_req = mem_request;
        compared++; if (data_valid !== 1'b0) begin mismatched++; $display("FAIL romwr_valid_early: got %b expected 0", data_valid); end
        @(negedge clock);
        saw_req = saw_req | mem_request;
        compared++; if (data_valid !== 1'b1 || saw_req !== 1'b0) begin mismatched++; $display("FAIL romwr: got valid=%b req_seen=%b expected 1/0", data_valid, saw_req); end
        strobe_req(16'h0800, 1'b1, 1'b0, 8'h00); @(negedge clock); @(negedge clock);
        compared++; if (rdata !== 8'h42) begin mismatched++; $display("FAIL romwr_ram_intact: got %h expected 42", rdata); end
    endtask

    task automatic test_read_write_together;
        strobe_req(16'h0055, 1'b1, 1'b1, 8'h99);
        @(negedge clock);
        compared++; if (data_valid !== 1'b1) begin mismatched++; $display("FAIL rw_valid_1clk: got %b expected 1", data_valid); end
        strobe_req(16'h1855, 1'b1, 1'b0, 8'h00); @(negedge clock); @(negedge clock);
        compared++; if (rdata !== 8'h99) begin mismatched++; $display("FAIL rw_write_wins: got %h expected 99", rdata); end
    endtask

    task automatic test_reset_mid_rom;
        strobe_req(16'h8000, 1'b1, 1'b0, 8'h00);
        @(negedge clock);
        compared++; if (mem_request !== 1'b1) begin mismatched++; $display("FAIL midrst_req: got %b expected 1", mem_request); end
        reset = 1'b1; bus_read = 1'b0;
        @(negedge clock);
        compared++; if (mem_request !== 1'b0) begin mismatched++; $display("FAIL midrst_req_drop: got %b expected 0", mem_request); end
        reset = 1'b0;
        @(negedge clock);
        mem_ack = 1'b1; mem_data = 8'h55;
        @(negedge clock);
        mem_ack = 1'b0;
        @(negedge clock);
        compared++; if (data_valid !== 1'b0 || rdata !== 8'h00 || mem_request !== 1'b0) begin mismatched++; $display("FAIL late_ack: got valid=%b data=%h req=%b expected 0/00/0", data_valid, rdata, mem_request); end
    endtask

    initial begin
        test_reset;
        test_ram_mirror;
        test_open_bus;
        test_rom_timeout;
        test_stale_rom;
        test_rom_write;
        test_read_write_together;
        test_reset_mid_rom;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
